// File: rtl/depthwise_conv_3_3.sv
// depthwise_conv_3_3: 3x3 depthwise convolution of one input tile, one
// channel at a time, with Q4.(PX_W-4) fixed-point arithmetic, zero padding
// at the tile border, optional stride 2 and a ReLU6 clip on every output.
module depthwise_conv_3_3 #(
    parameter int PX_W = 16,
    parameter int TIX  = 8,
    parameter int TIY  = 8,
    parameter int NCH  = 4,
    parameter int AW   = 10,
    parameter int KW   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stride2,
    output logic [AW-1:0]          fmint_addr,
    input  logic signed [PX_W-1:0] fmint_data,
    output logic [KW-1:0]          kdw_addr,
    input  logic signed [PX_W-1:0] kdw_data,
    output logic [AW-1:0]          fmdw_addr,
    output logic signed [PX_W-1:0] fmdw_data,
    output logic                   fmdw_we,
    output logic                   busy,
    output logic                   finish
);

    localparam int ACC_W  = PX_W + 4;
    localparam int PROD_W = 2 * PX_W;
    localparam int CNT_W  = 16;

    // 6.0 in the accumulator's fixed-point format
    localparam logic signed [ACC_W-1:0] SIX = ACC_W'(32'sd6 <<< (PX_W - 4));

    localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(NCH - 1);
    localparam logic [CNT_W-1:0] OX_LAST_S1  = CNT_W'(TIX - 1);
    localparam logic [CNT_W-1:0] OY_LAST_S1  = CNT_W'(TIY - 1);
    localparam logic [CNT_W-1:0] OX_LAST_S2  = CNT_W'((TIX + 1) / 2 - 1);
    localparam logic [CNT_W-1:0] OY_LAST_S2  = CNT_W'((TIY + 1) / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COMP  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // One tap's contribution: middle PX_W bits of the full product plus round bit.
    function automatic logic signed [ACC_W-1:0] tap_term(
        input logic signed [PX_W-1:0] px,
        input logic signed [PX_W-1:0] wt
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [PX_W-1:0]   mid;
        prod     = px * wt;
        mid      = prod[PROD_W-5:PX_W-4];
        tap_term = ACC_W'(mid) + {{(ACC_W-1){1'b0}}, prod[PX_W-5]};
    endfunction

    // Clip accumulator to [0, 6.0] and narrow to pixel width.
    function automatic logic [PX_W-1:0] relu6(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1]) begin
            relu6 = {PX_W{1'b0}};
        end else if (a > SIX) begin
            relu6 = SIX[PX_W-1:0];
        end else begin
            relu6 = a[PX_W-1:0];
        end
    endfunction

    // True when tap t of output (ox,oy) lands inside the tile.
    function automatic logic tap_in_tile(input int t, input int ox, input int oy, input logic s2);
        int s;
        int ix;
        int iy;
        s  = s2 ? 32'sd2 : 32'sd1;
        iy = s * oy + t / 32'sd3 - 32'sd1;
        ix = s * ox + t % 32'sd3 - 32'sd1;
        tap_in_tile = (ix >= 32'sd0) && (ix < TIX) && (iy >= 32'sd0) && (iy < TIY);
    endfunction

    // FMINT address of tap t; padded taps read address 0 (data is discarded).
    function automatic logic [AW-1:0] tap_addr(input int t, input int ox, input int oy,
                                               input int c, input logic s2);
        int s;
        int a;
        s = s2 ? 32'sd2 : 32'sd1;
        if (tap_in_tile(t, ox, oy, s2)) begin
            a = c * TIX * TIY + (s * oy + t / 32'sd3 - 32'sd1) * TIX
                + (s * ox + t % 32'sd3 - 32'sd1);
        end else begin
            a = 32'sd0;
        end
        tap_addr = a[AW-1:0];
    endfunction

    // Weight buffer address for weight k of channel c.
    function automatic logic [KW-1:0] wt_addr(input int c, input int k);
        int a;
        a       = 32'sd9 * c + k;
        wt_addr = a[KW-1:0];
    endfunction

    // FMDW address of output (ox,oy) of channel c for the given stride.
    function automatic logic [AW-1:0] out_addr(input int ox, input int oy, input int c,
                                               input logic s2);
        int oxn;
        int oyn;
        int a;
        oxn      = s2 ? (TIX + 1) / 2 : TIX;
        oyn      = s2 ? (TIY + 1) / 2 : TIY;
        a        = c * oxn * oyn + oy * oxn + ox;
        out_addr = a[AW-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]         ox_q, ox_d, oy_q, oy_d, c_q, c_d;
    logic                     s2_q, s2_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PX_W-1:0]   wt_q [0:8];
    logic signed [PX_W-1:0]   wt_d [0:8];
    logic [CNT_W-1:0]         ox_last_s, oy_last_s;

    logic [AW-1:0]            fmint_addr_q, fmint_addr_d;
    logic [KW-1:0]            kdw_addr_q, kdw_addr_d;
    logic [AW-1:0]            fmdw_addr_q, fmdw_addr_d;
    logic [PX_W-1:0]          fmdw_data_q, fmdw_data_d;
    logic                     fmdw_we_q, fmdw_we_d;
    logic                     busy_q, busy_d;
    logic                     finish_q, finish_d;

    // Last output column/row index for the stride latched at start.
    always_comb begin
        if (s2_q) begin
            ox_last_s = OX_LAST_S2;
            oy_last_s = OY_LAST_S2;
        end else begin
            ox_last_s = OX_LAST_S1;
            oy_last_s = OY_LAST_S1;
        end
    end

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        c_d     = c_q;
        s2_d    = s2_q;
        acc_d   = acc_q;
        for (int i = 0; i < 9; i++) begin
            wt_d[i] = wt_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = 4'd0;
                    ox_d    = {CNT_W{1'b0}};
                    oy_d    = {CNT_W{1'b0}};
                    c_d     = {CNT_W{1'b0}};
                    s2_d    = stride2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // weight k arrives one cycle after its address
                if (cnt_q != 4'd0) begin
                    wt_d[cnt_q - 4'd1] = kdw_data;
                end else begin
                    wt_d[0] = wt_q[0];
                end
                if (cnt_q == 4'd9) begin
                    state_d = ST_COMP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_COMP: begin
                // cycle 0 clears, cycles 1..9 add the tap whose data just arrived
                if (cnt_q == 4'd0) begin
                    acc_d = {ACC_W{1'b0}};
                end else if (tap_in_tile(int'(cnt_q) - 32'sd1, int'(ox_q), int'(oy_q), s2_q)) begin
                    acc_d = acc_q + tap_term(fmint_data, wt_q[cnt_q - 4'd1]);
                end else begin
                    acc_d = acc_q;
                end
                if (cnt_q == 4'd9) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WRITE: begin
                cnt_d = 4'd0;
                if (ox_q == ox_last_s) begin
                    ox_d = {CNT_W{1'b0}};
                    if (oy_q == oy_last_s) begin
                        oy_d = {CNT_W{1'b0}};
                        if (c_q == C_LAST) begin
                            state_d = ST_FIN;
                        end else begin
                            c_d     = c_q + 16'd1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        oy_d    = oy_q + 16'd1;
                        state_d = ST_COMP;
                    end
                end else begin
                    ox_d    = ox_q + 16'd1;
                    state_d = ST_COMP;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // addresses are registered so they line up with the cycle they belong to
        if (state_d == ST_COMP && cnt_d < 4'd9) begin
            fmint_addr_d = tap_addr(int'(cnt_d), int'(ox_d), int'(oy_d), int'(c_d), s2_d);
        end else begin
            fmint_addr_d = {AW{1'b0}};
        end
        if (state_d == ST_LOAD && cnt_d < 4'd9) begin
            kdw_addr_d = wt_addr(int'(c_d), int'(cnt_d));
        end else begin
            kdw_addr_d = {KW{1'b0}};
        end
        // output pixel is held until the next write
        if (state_d == ST_WRITE) begin
            fmdw_addr_d = out_addr(int'(ox_q), int'(oy_q), int'(c_q), s2_q);
            fmdw_data_d = relu6(acc_d);
        end else begin
            fmdw_addr_d = fmdw_addr_q;
            fmdw_data_d = fmdw_data_q;
        end
        fmdw_we_d = (state_d == ST_WRITE);
        busy_d    = (state_d != ST_IDLE);
        finish_d  = (state_d == ST_FIN);
    end

    // State, datapath and output registers; reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            ox_q         <= {CNT_W{1'b0}};
            oy_q         <= {CNT_W{1'b0}};
            c_q          <= {CNT_W{1'b0}};
            s2_q         <= 1'b0;
            acc_q        <= {ACC_W{1'b0}};
            for (int i = 0; i < 9; i++) begin
                wt_q[i] <= {PX_W{1'b0}};
            end
            fmint_addr_q <= {AW{1'b0}};
            kdw_addr_q   <= {KW{1'b0}};
            fmdw_addr_q  <= {AW{1'b0}};
            fmdw_data_q  <= {PX_W{1'b0}};
            fmdw_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            c_q          <= c_d;
            s2_q         <= s2_d;
            acc_q        <= acc_d;
            for (int i = 0; i < 9; i++) begin
                wt_q[i] <= wt_d[i];
            end
            fmint_addr_q <= fmint_addr_d;
            kdw_addr_q   <= kdw_addr_d;
            fmdw_addr_q  <= fmdw_addr_d;
            fmdw_data_q  <= fmdw_data_d;
            fmdw_we_q    <= fmdw_we_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
        end
    end

    assign fmint_addr = fmint_addr_q;
    assign kdw_addr   = kdw_addr_q;
    assign fmdw_addr  = fmdw_addr_q;
    assign fmdw_data  = fmdw_data_q;
    assign fmdw_we    = fmdw_we_q;
    assign busy       = busy_q;
    assign finish     = finish_q;

endmodule
